div_hilo_capture: RTL and testbench

Sequential capture stage downstream of the combinational 32-bit signed divider. It treats the divider as a multicycle path: on `start` it waits a fixed number of settle cycles, then loads the divider's 64-bit {remainder, quotient} result into the HI/LO register pair and pulses `done`. It also detects a zero divisor, supports direct HI/LO writes from the bus, and exposes HI/LO to the datapath.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_hilo_capture_hilo_reg.sv | 27 ++
 rtl/div_hilo_capture.sv | 132 +++++++++++++
 tb/tb_div_hilo_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider capture stage.
package div_pkg;

    localparam int DIV_CNT_W = 4;
    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_SETTLE  = 2'd1,
        DIV_CAPTURE = 2'd2
    } div_state_t;

    // True when the presented divisor is zero.
    function automatic logic is_zero(input logic [DIV_WIDTH-1:0] v);
        return (v == {DIV_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/div_hilo_capture_hilo_reg.sv
// 32-bit register with synchronous clear and load enable (one HI or LO half).
module hilo_reg
    import div_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] d,
    output logic [DIV_WIDTH-1:0] q
);

    logic [DIV_WIDTH-1:0] q_r;

    // Hold the value; clear wins over load.
    always_ff @(posedge clock) begin
        if (clear) begin
            q_r <= {DIV_WIDTH{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/div_hilo_capture.sv
// Capture stage for the combinational divider: waits a fixed settle time
// after start, then loads {remainder, quotient} into HI/LO and pulses done.
// Also flags zero divisors and allows direct HI/LO writes while idle.
module div_hilo_capture
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   start,
    input  logic [DIV_WIDTH-1:0]   m_in,
    input  logic [2*DIV_WIDTH-1:0] qr_in,
    input  logic [DIV_WIDTH-1:0]   bus_in,
    input  logic                   hi_write,
    input  logic                   lo_write,
    output logic [DIV_WIDTH-1:0]   hi_out,
    output logic [DIV_WIDTH-1:0]   lo_out,
    output logic                   busy,
    output logic                   done,
    output logic                   dz
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);
    localparam logic [DIV_CNT_W-1:0] CNT_ZERO = DIV_CNT_W'(0);

    div_state_t           state_r;
    div_state_t           state_s;
    logic [DIV_CNT_W-1:0] cnt_r;
    logic [DIV_CNT_W-1:0] cnt_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 done_r;
    logic                 done_s;
    logic                 dz_r;
    logic                 dz_s;
    logic                 hi_load_s;
    logic                 lo_load_s;
    logic [DIV_WIDTH-1:0] hi_d_s;
    logic [DIV_WIDTH-1:0] lo_d_s;

    // State and status registers; clear aborts any operation without a done pulse.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= DIV_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            dz_r    <= dz_s;
        end
    end

    // Next-state, counter, status and HI/LO load decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        dz_s      = dz_r;
        hi_load_s = 1'b0;
        lo_load_s = 1'b0;
        hi_d_s    = bus_in;
        lo_d_s    = bus_in;
        case (state_r)
            DIV_IDLE: begin
                if (start) begin
                    // start wins; same-cycle bus writes are dropped
                    if (is_zero(m_in)) begin
                        dz_s   = 1'b1;
                        done_s = 1'b1;
                    end else begin
                        state_s = DIV_SETTLE;
                        cnt_s   = CNT_LOAD;
                        dz_s    = 1'b0;
                        busy_s  = 1'b1;
                    end
                end else begin
                    hi_load_s = hi_write;
                    lo_load_s = lo_write;
                end
            end
            DIV_SETTLE: begin
                busy_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_s = DIV_CAPTURE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            DIV_CAPTURE: begin
                // operands are held stable upstream, so qr_in is valid here
                hi_load_s = 1'b1;
                lo_load_s = 1'b1;
                hi_d_s    = qr_in[2*DIV_WIDTH-1:DIV_WIDTH];
                lo_d_s    = qr_in[DIV_WIDTH-1:0];
                done_s    = 1'b1;
                state_s   = DIV_IDLE;
            end
            default: begin
                state_s = DIV_IDLE;
            end
        endcase
    end

    hilo_reg u_hi (
        .clock (clock),
        .clear (clear),
        .load  (hi_load_s),
        .d     (hi_d_s),
        .q     (hi_out)
    );

    hilo_reg u_lo (
        .clock (clock),
        .clear (clear),
        .load  (lo_load_s),
        .d     (lo_d_s),
        .q     (lo_out)
    );

    assign busy = busy_r;
    assign done = done_r;
    assign dz   = dz_r;

endmodule

// File: tb/tb_div_hilo_capture.sv
// Self-checking bench: directed table, hand sequences and randomized run
// against a countdown-based reference model, for SETTLE_CYCLES = 4 and 1.
module tb_div_hilo_capture;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] m_in;
    logic [63:0] qr_in;
    logic [31:0] bus_in;
    logic        hi_write;
    logic        lo_write;

    logic [31:0] a_hi, a_lo, b_hi, b_lo;
    logic        a_busy, a_done, a_dz, b_busy, b_done, b_dz;

    int n_pass  = 0;
    int n_total = 0;

    // model state per instance: 0 = default (4), 1 = minimum settle (1)
    logic [31:0] e_hi [2];
    logic [31:0] e_lo [2];
    logic        e_busy [2];
    logic        e_done [2];
    logic        e_dz [2];
    int          rem [2];
    int          settle [2];

    typedef struct {
        logic        start;
        logic [31:0] m;
        logic [63:0] qr;
        logic [31:0] bus;
        logic        hw;
        logic        lw;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
        logic        x_busy;
        logic        x_done;
        logic        x_dz;
    } vec_t;

    vec_t tbl [20];

    always #5 clock = ~clock;

    div_hilo_capture #(.SETTLE_CYCLES(4)) dut_a (
        .clock(clock), .clear(clear), .start(start), .m_in(m_in), .qr_in(qr_in),
        .bus_in(bus_in), .hi_write(hi_write), .lo_write(lo_write),
        .hi_out(a_hi), .lo_out(a_lo), .busy(a_busy), .done(a_done), .dz(a_dz)
    );

    div_hilo_capture #(.SETTLE_CYCLES(1)) dut_b (
        .clock(clock), .clear(clear), .start(start), .m_in(m_in), .qr_in(qr_in),
        .bus_in(bus_in), .hi_write(hi_write), .lo_write(lo_write),
        .hi_out(b_hi), .lo_out(b_lo), .busy(b_busy), .done(b_done), .dz(b_dz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs after the coming edge, from the inputs presented now.
    // rem counts edges left until the result is taken: busy while rem > 0.
    task automatic model_edge(input int k);
        if (clear) begin
            e_hi[k] = 32'd0; e_lo[k] = 32'd0; e_busy[k] = 1'b0;
            e_done[k] = 1'b0; e_dz[k] = 1'b0; rem[k] = 0;
        end else if (rem[k] > 0) begin
            rem[k]--;
            if (rem[k] == 0) begin
                e_hi[k] = qr_in[63:32]; e_lo[k] = qr_in[31:0];
                e_done[k] = 1'b1; e_busy[k] = 1'b0;
            end else begin
                e_done[k] = 1'b0; e_busy[k] = 1'b1;
            end
        end else begin
            e_done[k] = 1'b0;
            if (start) begin
                if (m_in == 32'd0) begin
                    e_dz[k] = 1'b1; e_done[k] = 1'b1;
                end else begin
                    e_dz[k] = 1'b0; rem[k] = settle[k] + 1; e_busy[k] = 1'b1;
                end
            end else begin
                if (hi_write) e_hi[k] = bus_in;
                if (lo_write) e_lo[k] = bus_in;
            end
        end
    endtask

    // Advance one clock edge, then compare both instances against the model.
    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clock);
        #1;
        check("a_hi", a_hi, e_hi[0]);
        check("a_lo", a_lo, e_lo[0]);
        check("a_busy", {31'd0, a_busy}, {31'd0, e_busy[0]});
        check("a_done", {31'd0, a_done}, {31'd0, e_done[0]});
        check("a_dz", {31'd0, a_dz}, {31'd0, e_dz[0]});
        check("b_hi", b_hi, e_hi[1]);
        check("b_lo", b_lo, e_lo[1]);
        check("b_busy", {31'd0, b_busy}, {31'd0, e_busy[1]});
        check("b_done", {31'd0, b_done}, {31'd0, e_done[1]});
        check("b_dz", {31'd0, b_dz}, {31'd0, e_dz[1]});
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] m, input logic [63:0] qr,
                                input logic [31:0] bus, input logic hw, input logic lw,
                                input logic [31:0] xh, input logic [31:0] xl,
                                input logic xb, input logic xd, input logic xz);
        vec_t v;
        v.start = st; v.m = m; v.qr = qr; v.bus = bus; v.hw = hw; v.lw = lw;
        v.x_hi = xh; v.x_lo = xl; v.x_busy = xb; v.x_done = xd; v.x_dz = xz;
        return v;
    endfunction

    task automatic idle_inputs();
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    endtask

    initial begin
        logic [63:0] q1;
        logic [63:0] q2;
        int          done_seen;
        int          busy_ops;
        q1 = {32'd2, 32'd14};
        q2 = {32'd0, 32'hFFFF_FFF2};
        settle[0] = 4;
        settle[1] = 1;
        rem[0] = 0;
        rem[1] = 0;

        // Expected values for the 4-cycle instance after each row's edge.
        //           st    m      qr     bus            hw    lw    hi             lo             busy  done  dz
        tbl[0]  = mk(1'b0, 32'd0, 64'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 32'd0, 64'd0, 32'h9ABC_DEF0, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 32'd0, 64'd0, 32'h0F0F_0F0F, 1'b1, 1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 32'd0, 64'd0, 32'hAAAA_0000, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 32'd0, 64'd0, 32'h0000_5555, 1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 32'd0, 64'd0, 32'h0,         1'b0, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b1, 1'b1);
        tbl[6]  = mk(1'b0, 32'd0, 64'd0, 32'h0,         1'b0, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 32'd7, q1,    32'hFFFF_FFFF, 1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 32'd7, q1,    32'h0,         1'b0, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 32'd7, q1,    32'hDEAD_BEEF, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 32'd7, q1,    32'h0,         1'b0, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 32'd7, q1,    32'h0,         1'b0, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 32'd7, q1,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b0, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b1, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b1, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b1, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b1, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd2,         32'd14,        1'b1, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd0,         32'hFFFF_FFF2, 1'b0, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, 32'd3, q2,    32'h0,         1'b0, 1'b0, 32'd0,         32'hFFFF_FFF2, 1'b0, 1'b0, 1'b0);

        // Reset
        clear = 1'b1; idle_inputs(); m_in = 32'd0; qr_in = 64'd0; bus_in = 32'd0;
        cycle();
        cycle();
        check("rst_hi", a_hi, 32'd0);
        check("rst_lo", a_lo, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_done", {31'd0, a_done}, 32'd0);
        check("rst_dz", {31'd0, a_dz}, 32'd0);
        clear = 1'b0;

        // Directed table: writes, zero divisor, busy-time requests, back-to-back
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].start; m_in = tbl[i].m; qr_in = tbl[i].qr;
            bus_in = tbl[i].bus; hi_write = tbl[i].hw; lo_write = tbl[i].lw;
            cycle();
            check($sformatf("tbl%0d_hi", i), a_hi, tbl[i].x_hi);
            check($sformatf("tbl%0d_lo", i), a_lo, tbl[i].x_lo);
            check($sformatf("tbl%0d_busy", i), {31'd0, a_busy}, {31'd0, tbl[i].x_busy});
            check($sformatf("tbl%0d_done", i), {31'd0, a_done}, {31'd0, tbl[i].x_done});
            check($sformatf("tbl%0d_dz", i), {31'd0, a_dz}, {31'd0, tbl[i].x_dz});
        end
        idle_inputs();

        // Clear in the middle of SETTLE: everything zero, no late done
        start = 1'b1; m_in = 32'd5; qr_in = {32'd11, 32'd22};
        cycle();
        start = 1'b0;
        cycle();
        clear = 1'b1;
        cycle();
        check("clr_hi", a_hi, 32'd0);
        check("clr_lo", a_lo, 32'd0);
        check("clr_busy", {31'd0, a_busy}, 32'd0);
        check("clr_done", {31'd0, a_done}, 32'd0);
        clear = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (a_done) done_seen++;
        end
        check("clr_no_done", done_seen, 32'd0);

        // Randomized run; operands change only while both instances are idle
        busy_ops = 0;
        for (int i = 0; i < 600; i++) begin
            clear    = ($urandom_range(0, 79) == 0);
            start    = ($urandom_range(0, 3) == 0);
            hi_write = ($urandom_range(0, 2) == 0);
            lo_write = ($urandom_range(0, 2) == 0);
            bus_in   = $urandom;
            if (rem[0] == 0 && rem[1] == 0) begin
                m_in  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                qr_in = {$urandom, $urandom};
            end
            cycle();
            if (a_busy) busy_ops++;
        end
        check("rand_exercised_busy", {31'd0, busy_ops > 0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
